// File: rtl/sparc_mem_responder_pkg.sv
// Shared definitions for the MOV/MOC memory responder: access type codes,
// FSM state encoding and the latched request record.
package sparc_mem_responder_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [1:0] TYPE_BYTE     = 2'b00;
  localparam logic [1:0] TYPE_HALF     = 2'b01;
  localparam logic [1:0] TYPE_WORD     = 2'b10;
  localparam logic [1:0] TYPE_WORD_ALT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [1:0]        typ;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/sparc_mem_responder_if.sv
// MOV/MOC handshake bundle between the CPU-side initiator and the memory responder.
interface sparc_mem_responder_if;
  import sparc_mem_responder_pkg::*;

  logic              MOV;
  logic              RW;
  logic [1:0]        Type;
  logic              Sign_Ext;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Data_In;
  logic [DATA_W-1:0] Data_Out;
  logic              MOC;
  logic              Align_Err;

  modport master (
    output MOV, RW, Type, Sign_Ext, Address, Data_In,
    input  Data_Out, MOC, Align_Err
  );

  modport slave (
    input  MOV, RW, Type, Sign_Ext, Address, Data_In,
    output Data_Out, MOC, Align_Err
  );

endinterface

// File: rtl/sparc_mem_responder_lane_align.sv
// Combinational size/alignment unit: big-endian lane enables, write packing,
// read unpacking with sign/zero extension, and the misalignment flag.
module mem_lane_align
  import sparc_mem_responder_pkg::*;
(
  input  logic [1:0]        type_i,
  input  logic [1:0]        addr_i,
  input  logic              sext_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rbytes_i,
  output logic [3:0]        lane_en_o,
  output logic [DATA_W-1:0] wbytes_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misalign_o
);

  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic s);
    return {{(DATA_W-8){s & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic s);
    return {{(DATA_W-16){s & h[15]}}, h};
  endfunction

  // lane_en_o[i] selects the byte at Address+i; bytes are packed MSB-first
  always_comb begin
    lane_en_o  = 4'b0000;
    wbytes_o   = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    case (type_i)
      TYPE_BYTE: begin
        lane_en_o = 4'b0001;
        wbytes_o  = {wdata_i[7:0], 24'h0};
        rdata_o   = ext8(rbytes_i[31:24], sext_i);
      end
      TYPE_HALF: begin
        misalign_o = addr_i[0];
        lane_en_o  = 4'b0011;
        wbytes_o   = {wdata_i[15:0], 16'h0};
        rdata_o    = ext16(rbytes_i[31:16], sext_i);
      end
      default: begin
        misalign_o = |addr_i;
        lane_en_o  = 4'b1111;
        wbytes_o   = wdata_i;
        rdata_o    = rbytes_i;
      end
    endcase
  end

endmodule

// File: rtl/sparc_mem_responder.sv
// Memory-side responder: one access per MOV assertion, fixed latency, one-cycle
// MOC strobe, big-endian byte/half/word access to a byte-wide array.
module sparc_mem_responder
  import sparc_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  sparc_mem_responder_if.slave  bus
);

  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d, req_cur;
  logic              moc_q, moc_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              commit;
  logic              wr_en;

  logic [7:0]        mem_q [DEPTH];
  logic [IDX_W-1:0]  idx [4];
  logic [DATA_W-1:0] rbytes;
  logic [3:0]        lane_en;
  logic [DATA_W-1:0] wbytes;
  logic [DATA_W-1:0] rdata;
  logic              misalign;

  // In IDLE the live bus is the request, so a zero-latency access can commit on its sampling edge
  always_comb begin
    req_cur = (state_q == S_IDLE)
              ? {bus.RW, bus.Type, bus.Sign_Ext, bus.Address, bus.Data_In}
              : req_q;
  end

  always_comb begin
    rbytes = '0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = IDX_W'((int'(req_cur.addr) + i) % DEPTH);
      rbytes[8*(3-i) +: 8] = mem_q[idx[i]];
    end
  end

  mem_lane_align u_lane (
    .type_i     (req_cur.typ),
    .addr_i     (req_cur.addr[1:0]),
    .sext_i     (req_cur.sext),
    .wdata_i    (req_cur.data),
    .rbytes_i   (rbytes),
    .lane_en_o  (lane_en),
    .wbytes_o   (wbytes),
    .rdata_o    (rdata),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.MOV) begin
          req_d = req_cur;
          if (LATENCY == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(CNT_INIT);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK:     state_d = S_RELEASE;
      S_RELEASE: if (!bus.MOV) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    moc_d  = (state_q == S_ACK);
    err_d  = (state_q == S_ACK) && misalign;
    dout_d = (commit && req_cur.rw && !misalign) ? rdata : dout_q;
    wr_en  = commit && !req_cur.rw && !misalign;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge Clk) begin
    req_q <= req_d;
  end

  // Storage is deliberately left uninitialised by reset
  always_ff @(posedge Clk) begin
    if (Reset_n && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[idx[i]] <= wbytes[8*(3-i) +: 8];
      end
    end
  end

  assign bus.Data_Out  = dout_q;
  assign bus.MOC       = moc_q;
  assign bus.Align_Err = err_q;

endmodule

// File: tb/tb_sparc_mem_responder.sv
// Bench for sparc_mem_responder: directed handshake scenarios plus randomized
// accesses, checked against a byte-array reference model.
module tb_sparc_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sparc_mem_responder_if bus2 ();
  sparc_mem_responder_if bus0 ();

  sparc_mem_responder #(.DEPTH(512), .LATENCY(2)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus2.slave)
  );

  sparc_mem_responder #(.DEPTH(512), .LATENCY(0)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus0.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]  mem_m  [2][512];
  logic [31:0] dout_m [2];
  logic [31:0] obs_d;
  logic        obs_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: memory is a plain byte array, accesses are MSB-first byte sequences
  task automatic model(input int u, input logic rw, input logic [1:0] ty, input logic se,
                       input logic [8:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] q);
    int size;
    int nb;
    logic [31:0] v;
    size = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 4;
    e = (int'(a) % size) != 0;
    if (!e) begin
      if (rw) begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = (v << 8) | 32'(mem_m[u][(int'(a) + i) % 512]);
        nb = 8 * size;
        if (size < 4 && se && v[nb-1]) v = v | (32'hFFFF_FFFF << nb);
        dout_m[u] = v;
      end else begin
        for (int i = 0; i < size; i++)
          mem_m[u][(int'(a) + i) % 512] = 8'(d >> (8 * (size - 1 - i)));
      end
    end
    q = dout_m[u];
  endtask

  task automatic drive(input int u, input logic mov, input logic rw, input logic [1:0] ty,
                       input logic se, input logic [8:0] a, input logic [31:0] d);
    if (u == 1) begin
      bus0.MOV = mov; bus0.RW = rw; bus0.Type = ty;
      bus0.Sign_Ext = se; bus0.Address = a; bus0.Data_In = d;
    end else begin
      bus2.MOV = mov; bus2.RW = rw; bus2.Type = ty;
      bus2.Sign_Ext = se; bus2.Address = a; bus2.Data_In = d;
    end
  endtask

  function automatic logic g_moc(input int u);
    return (u == 1) ? bus0.MOC : bus2.MOC;
  endfunction

  function automatic logic g_err(input int u);
    return (u == 1) ? bus0.Align_Err : bus2.Align_Err;
  endfunction

  function automatic logic [31:0] g_dout(input int u);
    return (u == 1) ? bus0.Data_Out : bus2.Data_Out;
  endfunction

  // One full handshake; request inputs are scrambled right after the sampling edge
  task automatic access(input int u, input logic rw, input logic [1:0] ty, input logic se,
                        input logic [8:0] a, input logic [31:0] d, input int hold,
                        input string tag);
    logic        exp_e;
    logic [31:0] exp_d;
    int n;
    int extra;
    int lat;
    lat = (u == 1) ? 0 : 2;
    model(u, rw, ty, se, a, d, exp_e, exp_d);
    @(negedge clk);
    drive(u, 1'b1, rw, ty, se, a, d);
    @(posedge clk);
    #1 drive(u, 1'b1, ~rw, ~ty, ~se, ~a, ~d);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!g_moc(u) && n < 20);
    chk({tag, " latency"}, 32'(n), 32'(lat + 1));
    obs_d = g_dout(u);
    obs_e = g_err(u);
    chk({tag, " align_err"}, 32'(obs_e), 32'(exp_e));
    chk({tag, " data_out"}, obs_d, exp_d);
    extra = 0;
    for (int j = 0; j <= hold; j++) begin
      @(posedge clk);
      #1 if (g_moc(u)) extra++;
    end
    chk({tag, " extra_moc"}, 32'(extra), 32'd0);
    chk({tag, " err_idle"}, 32'(g_err(u)), 32'd0);
    @(negedge clk);
    drive(u, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
  endtask

  initial begin
    logic [1:0] ty;
    logic [8:0] a;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    dout_m[0] = 32'h0;
    dout_m[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst moc2", 32'(bus2.MOC), 32'd0);
    chk("rst err2", 32'(bus2.Align_Err), 32'd0);
    chk("rst dout2", bus2.Data_Out, 32'h0);
    chk("rst moc0", 32'(bus0.MOC), 32'd0);
    chk("rst dout0", bus0.Data_Out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    access(0, 1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 0, "t1 wr");
    access(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0, "t1 rd");
    chk("t1 const", obs_d, 32'hDEADBEEF);

    access(0, 1'b1, 2'b00, 1'b0, 9'h011, 32'h0, 0, "t2 rdb");
    chk("t2 const zext", obs_d, 32'h0000_00AD);
    access(0, 1'b1, 2'b00, 1'b1, 9'h010, 32'h0, 0, "t2 rdbs");
    chk("t2 const sext", obs_d, 32'hFFFF_FFDE);

    access(0, 1'b0, 2'b01, 1'b0, 9'h012, 32'h0000_1234, 0, "t3 wrh");
    access(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 0, "t3 rdw");
    chk("t3 const word", obs_d, 32'hDEAD1234);
    access(0, 1'b1, 2'b01, 1'b1, 9'h012, 32'h0, 0, "t3 rdh");
    chk("t3 const half", obs_d, 32'h0000_1234);

    access(0, 1'b0, 2'b10, 1'b0, 9'h013, 32'hCAFEF00D, 0, "t4 wrmis");
    chk("t4 const err", 32'(obs_e), 32'd1);
    access(0, 1'b1, 2'b11, 1'b0, 9'h010, 32'h0, 0, "t4 rd");
    chk("t4 const keep", obs_d, 32'hDEAD1234);

    access(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 6, "t5 hold");
    access(0, 1'b1, 2'b00, 1'b0, 9'h012, 32'h0, 0, "t5 next");
    chk("t5 const", obs_d, 32'h0000_0012);

    access(1, 1'b0, 2'b10, 1'b0, 9'h040, 32'h0F1E2D3C, 0, "l0 wr");
    access(1, 1'b1, 2'b00, 1'b1, 9'h041, 32'h0, 6, "l0 rdb");
    chk("l0 const byte", obs_d, 32'h0000_001E);
    access(1, 1'b1, 2'b01, 1'b1, 9'h042, 32'h0, 0, "l0 rdh");
    chk("l0 const half", obs_d, 32'h0000_2D3C);
    access(1, 1'b1, 2'b01, 1'b0, 9'h041, 32'h0, 0, "l0 mis");
    chk("l0 const err", 32'(obs_e), 32'd1);

    access(0, 1'b0, 2'b10, 1'b0, 9'h020, 32'hA5A5_5A5A, 0, "t6 pre");
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 9'h020, 32'h1111_1111);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    dout_m[0] = 32'h0;
    dout_m[1] = 32'h0;
    chk("t6 rst moc", 32'(bus2.MOC), 32'd0);
    chk("t6 rst dout", bus2.Data_Out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    access(0, 1'b1, 2'b10, 1'b0, 9'h020, 32'h0, 0, "t6 rd");
    chk("t6 const old", obs_d, 32'hA5A5_5A5A);

    for (int i = 0; i < 16; i++)
      access(0, 1'b0, 2'b10, 1'b0, 9'(9'h100 + 4 * i), $urandom, 0, "rnd init");
    for (int i = 0; i < 40; i++) begin
      ty = 2'($urandom_range(0, 3));
      a  = 9'(9'h100 + $urandom_range(0, 63));
      access(0, 1'($urandom_range(0, 1)), ty, 1'($urandom_range(0, 1)), a, $urandom,
             int'($urandom_range(0, 2)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
